// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port synchronous RAM.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (port A always wins contention).
module ram_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          resetn,

    input  logic          a_req,
    input  logic          a_wr,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,

    input  logic          b_req,
    input  logic          b_wr,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,

    output logic [DW-1:0] rdata,
    output logic          busy,

    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_dataIn,
    output logic          ram_we,
    output logic          ram_rd,
    input  logic [DW-1:0] ram_dataOut
);

    // Handshake: a requester raises *_req with stable operands and holds it
    // until the clock edge at which *_ack is sampled high; *_ack is a one-cycle
    // pulse, and rdata is meaningful only while a read's *_ack is high.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          grant_b_q, grant_b_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          pick_b;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign pick_b = b_req && !a_req;
`else
    logic last_b_q, last_b_d;

    // On contention the port that was not served last wins.
    assign pick_b = b_req && (!a_req || !last_b_q);
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            grant_b_q <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_b_q <= grant_b_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

`ifndef RAM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        grant_b_d = grant_b_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
`ifndef RAM_ARB_FIXED_PRIO_EN
        last_b_d  = last_b_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    state_d   = ST_ISSUE;
                    grant_b_d = pick_b;
                    wr_d      = pick_b ? b_wr    : a_wr;
                    addr_d    = pick_b ? b_addr  : a_addr;
                    wdata_d   = pick_b ? b_wdata : a_wdata;
                end
            end
            ST_ISSUE: begin
                state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
`ifndef RAM_ARB_FIXED_PRIO_EN
                last_b_d = grant_b_q;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Address and data stay on the latched copy so the RAM pins only move on a grant.
    assign ram_address = addr_q;
    assign ram_dataIn  = wdata_q;
    assign ram_we      = (state_q == ST_ISSUE) &&  wr_q;
    assign ram_rd      = (state_q == ST_ISSUE) && !wr_q;

    assign busy  = (state_q != ST_IDLE);
    assign a_ack = (state_q == ST_ACK) && !grant_b_q;
    assign b_ack = (state_q == ST_ACK) &&  grant_b_q;
    assign rdata = ((state_q == ST_ACK) && !wr_q) ? ram_dataOut : '0;

    a_strobes_exclusive: assert property (@(posedge clock) disable iff (!resetn)
        !(ram_we && ram_rd));
    a_acks_exclusive: assert property (@(posedge clock) disable iff (!resetn)
        !(a_ack && b_ack));
    a_ack_single_pulse: assert property (@(posedge clock) disable iff (!resetn)
        (a_ack || b_ack) |=> !(a_ack || b_ack));

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: transaction-schedule model, RAM model and directed/random traffic.
module tb_ram_arbiter;

    localparam logic [7:0] PRELOAD [16] = '{8'hAA, 8'h0F, 8'h02, 8'h02, 8'h04, 8'h55, 8'h06, 8'h07,
                                            8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};

    logic       clock = 1'b0;
    logic       resetn;
    logic       a_req, a_wr, b_req, b_wr;
    logic [3:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_ack, b_ack, busy, ram_we, ram_rd;
    logic [7:0] rdata, ram_dataIn;
    logic [3:0] ram_address;
    logic [7:0] ram_dataOut = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rd_cnt, we_cnt, b_ack_cnt;
    int         ack_cyc_q[$];
    bit         ack_port_q[$];
    logic [7:0] ack_data_q[$];

    always #5 clock = ~clock;

    ram_arbiter #(.AW(4), .DW(8)) dut (
        .clock(clock), .resetn(resetn),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack),
        .rdata(rdata), .busy(busy),
        .ram_address(ram_address), .ram_dataIn(ram_dataIn), .ram_we(ram_we), .ram_rd(ram_rd),
        .ram_dataOut(ram_dataOut)
    );

    // RAM: 16x8, write stored and read registered at the edge that sees the strobe.
    logic [7:0] mem [16] = PRELOAD;
    always @(posedge clock) begin
        if (ram_we) mem[ram_address] <= ram_dataIn;
        if (ram_rd) ram_dataOut <= mem[ram_address];
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: one transaction at a time, granted at edge t_edge,
    // RAM acts at t_edge+1, ack interval after t_edge+1, next grant no earlier than t_edge+3.
    logic [7:0] ref_mem [16] = PRELOAD;
    bit         t_valid = 1'b0;
    int         t_edge  = 0;
    bit         t_port  = 1'b0;
    bit         t_wr    = 1'b0;
    logic [3:0] t_addr  = 4'h0;
    logic [7:0] t_wdata = 8'h00;
    logic [7:0] t_rdata = 8'h00;
    bit         last_b  = 1'b1;
    logic [3:0] m_addr  = 4'h0;
    logic [7:0] m_wdata = 8'h00;

    function automatic bit winner_is_b(input bit ra, input bit rb, input bit lb);
`ifdef RAM_ARB_FIXED_PRIO_EN
        return rb && !ra;
`else
        if (ra && rb) return !lb;
        return rb;
`endif
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            t_valid <= 1'b0;
            last_b  <= 1'b1;
            m_addr  <= 4'h0;
            m_wdata <= 8'h00;
        end else begin
            if (t_valid && (cyc + 1 == t_edge + 1)) begin
                if (t_wr) ref_mem[t_addr] <= t_wdata;
                else      t_rdata <= ref_mem[t_addr];
            end
            if (t_valid && (cyc + 1 == t_edge + 2)) begin
                t_valid <= 1'b0;
                last_b  <= t_port;
            end
            if (!t_valid && (a_req || b_req)) begin
                t_valid <= 1'b1;
                t_edge  <= cyc + 1;
                t_port  <= winner_is_b(a_req, b_req, last_b);
                if (winner_is_b(a_req, b_req, last_b)) begin
                    t_wr <= b_wr; t_addr <= b_addr; t_wdata <= b_wdata;
                    m_addr <= b_addr; m_wdata <= b_wdata;
                end else begin
                    t_wr <= a_wr; t_addr <= a_addr; t_wdata <= a_wdata;
                    m_addr <= a_addr; m_wdata <= a_wdata;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    initial begin : compare_proc
        bit issue, ackc;
        forever begin
            @(negedge clock);
            issue = t_valid && (cyc == t_edge);
            ackc  = t_valid && (cyc == t_edge + 1);
            check("busy", busy, issue || ackc);
            check("ram_we", ram_we, issue && t_wr);
            check("ram_rd", ram_rd, issue && !t_wr);
            check("a_ack", a_ack, ackc && !t_port);
            check("b_ack", b_ack, ackc && t_port);
            check("ram_address", ram_address, m_addr);
            check("ram_dataIn", ram_dataIn, m_wdata);
            if (ackc || !resetn) check("rdata", rdata, (ackc && !t_wr) ? t_rdata : 8'h00);
            if (ram_rd) rd_cnt++;
            if (ram_we) we_cnt++;
            if (b_ack) b_ack_cnt++;
            if (a_ack || b_ack) begin
                ack_cyc_q.push_back(cyc);
                ack_port_q.push_back(b_ack);
                ack_data_q.push_back(rdata);
            end
        end
    end

    // One transaction on a port; entered #1 after a rising edge, returns #1 after the ack edge.
    task automatic port_txn(input bit port, input bit wr, input logic [3:0] addr, input logic [7:0] wdata,
                            input int alt_addr, output logic [7:0] rd, output int lat);
        int  start;
        int  budget;
        bit  done;
        start = cyc;
        if (!port) begin a_req = 1'b1; a_wr = wr; a_addr = addr; a_wdata = wdata; end
        else       begin b_req = 1'b1; b_wr = wr; b_addr = addr; b_wdata = wdata; end
        @(posedge clock);
        if (alt_addr >= 0) begin
            #1;
            if (!port) a_addr = 4'(alt_addr); else b_addr = 4'(alt_addr);
        end
        rd = 8'h00; lat = -1; budget = 0; done = 1'b0;
        while (!done) begin
            @(negedge clock);
            if ((!port && a_ack) || (port && b_ack)) begin
                rd = rdata; lat = cyc - start; done = 1'b1;
            end else begin
                budget++;
                if (budget > 60) begin
                    n_tests++; n_fail++;
                    $display("FAIL ack_timeout port=%0d actual=no_ack required=ack", port);
                    done = 1'b1;
                end
            end
        end
        @(posedge clock); #1;
        if (!port) begin a_req = 1'b0; a_addr = 4'($urandom_range(0, 15)); a_wdata = 8'($urandom_range(0, 255)); end
        else       begin b_req = 1'b0; b_addr = 4'($urandom_range(0, 15)); b_wdata = 8'($urandom_range(0, 255)); end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
    endtask

    task automatic rand_gap();
        int n;
        n = $urandom_range(0, 3);
        if (n > 0) begin
            repeat (n) @(posedge clock);
            #1;
        end
    endtask

    initial begin : main_proc
        logic [7:0] rd;
        int         lat;
        bit         exp_p [3];
        logic [7:0] exp_d [3];
        a_req = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_wr = 0; b_addr = 0; b_wdata = 0;
        rd_cnt = 0; we_cnt = 0; b_ack_cnt = 0;
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;

        // A reads address 0 right after reset.
        rd_cnt = 0; we_cnt = 0;
        port_txn(1'b0, 1'b0, 4'd0, 8'h00, -1, rd, lat);
        check("t1_rdata", rd, 8'hAA);
        check("t1_latency", lat, 2);
        check("t1_rd_cycles", rd_cnt, 1);
        check("t1_we_cycles", we_cnt, 0);

        // B writes 0x5C to 7, then A reads 7 back.
        port_txn(1'b1, 1'b1, 4'd7, 8'h5C, -1, rd, lat);
        check("t2_b_latency", lat, 2);
        check("t2_b_rdata", rd, 8'h00);
        port_txn(1'b0, 1'b0, 4'd7, 8'h00, -1, rd, lat);
        check("t2_a_rdata", rd, 8'h5C);
        check("t2_a_latency", lat, 2);

        // Contention from reset: both ports request reads in the same cycle, A holds for two.
        do_reset();
        ack_cyc_q.delete(); ack_port_q.delete(); ack_data_q.delete();
        fork
            begin : cont_a
                logic [7:0] r; int l;
                port_txn(1'b0, 1'b0, 4'd1, 8'h00, -1, r, l);
                port_txn(1'b0, 1'b0, 4'd1, 8'h00, -1, r, l);
            end
            begin : cont_b
                logic [7:0] r; int l;
                port_txn(1'b1, 1'b0, 4'd2, 8'h00, -1, r, l);
            end
        join
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_p = '{1'b0, 1'b0, 1'b1};
        exp_d = '{8'h0F, 8'h0F, 8'h02};
`else
        exp_p = '{1'b0, 1'b1, 1'b0};
        exp_d = '{8'h0F, 8'h02, 8'h0F};
`endif
        check("t3_ack_count", ack_cyc_q.size(), 3);
        if (ack_cyc_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("t3_ack_port", ack_port_q[i], exp_p[i]);
                check("t3_ack_rdata", ack_data_q[i], exp_d[i]);
            end
            check("t3_spacing_1", ack_cyc_q[1] - ack_cyc_q[0], 3);
            check("t3_spacing_2", ack_cyc_q[2] - ack_cyc_q[1], 3);
        end

        // Reset asserted during ISSUE of a B write to 9.
        b_req = 1'b1; b_wr = 1'b1; b_addr = 4'd9; b_wdata = 8'h33;
        @(posedge clock); #1;
        check("t4_we_in_issue", ram_we, 1'b1);
        b_ack_cnt = 0;
        resetn = 1'b0;
        #1;
        check("t4_outputs_zero",
              {a_ack, b_ack, rdata, busy, ram_address, ram_dataIn, ram_we, ram_rd}, 32'h0);
        b_req = 1'b0;
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("t4_idle_busy", busy, 1'b0);
        check("t4_no_b_ack", b_ack_cnt, 0);
        port_txn(1'b0, 1'b0, 4'd9, 8'h00, -1, rd, lat);
        check("t4_write_not_landed", rd, 8'h09);

        // Address changes from 3 to 5 during ISSUE; the latched 3 is used.
        port_txn(1'b0, 1'b0, 4'd3, 8'h00, 5, rd, lat);
        check("t5_rdata", rd, 8'h02);
        check("t5_latency", lat, 2);

        // Random concurrent traffic on both ports.
        fork
            begin : rnd_a
                logic [7:0] r; int l;
                for (int i = 0; i < 60; i++) begin
                    rand_gap();
                    port_txn(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                             8'($urandom_range(0, 255)), -1, r, l);
                end
            end
            begin : rnd_b
                logic [7:0] r; int l;
                for (int i = 0; i < 60; i++) begin
                    rand_gap();
                    port_txn(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                             8'($urandom_range(0, 255)), -1, r, l);
                end
            end
        join

        repeat (4) @(posedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
